// File: rtl/encoder_16_4_seq.sv
// Sequential 16:4 priority encoder: latches request lines into a pending set
// and streams their indices out over a valid/ready handshake.
module encoder_16_4_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic        en_in,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_valid,
    output logic [15:0] pending,
    output logic        overflow
);

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [IW-1:0]   out_idx_q, out_idx_d;
    logic            overflow_q, overflow_d;

    logic            acc_c;
    logic [N-1:0]    clr_c;
    logic [N-1:0]    cap_c;
    logic [N-1:0]    remain_c;

    // Index of the winning request in v under the configured priority.
    function automatic logic [IW-1:0] prio(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (LSB_FIRST) begin
                if (v[N-1-i]) idx = IW'(N - 1 - i);
            end else begin
                if (v[i]) idx = IW'(i);
            end
        end
        return idx;
    endfunction

    // Pending set: retire the accepted index, merge newly captured requests.
    always_comb begin
        acc_c      = (state_q == HOLD) && out_ready;
        clr_c      = acc_c ? (N'(1) << out_idx_q) : '0;
        cap_c      = en_in ? in : '0;
        remain_c   = pending_q & ~clr_c;
        pending_d  = remain_c | cap_c;
        overflow_d = overflow_q | (|(cap_c & remain_c));
    end

    // Output stage: present one index, advance only on handshake.
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        case (state_q)
            IDLE: begin
                if (|remain_c) begin
                    out_idx_d = prio(remain_c);
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (|remain_c) begin
                        out_idx_d = prio(remain_c);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_idx_q  <= out_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == HOLD);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_encoder_16_4_seq.sv
// Bench for encoder_16_4_seq: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a behavioural model plus directed literals.
module tb_encoder_16_4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_v;
    logic        en_in;
    logic        out_ready;

    logic [3:0]  idx0, idx1;
    logic        val0, val1;
    logic [15:0] pend0, pend1;
    logic        ovf0, ovf1;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int log0[$];
    int log1[$];

    // Model state, index 0 = lowest-first, index 1 = highest-first
    logic [15:0] m_pend[2];
    int          m_idx[2];
    bit          m_val[2];
    bit          m_ovf[2];
    logic [15:0] m_rem, m_cap;
    bit          m_acc;

    always #5 clk = ~clk;

    encoder_16_4_seq #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in(in_v), .en_in(en_in), .out_ready(out_ready),
        .out_idx(idx0), .out_valid(val0), .pending(pend0), .overflow(ovf0)
    );

    encoder_16_4_seq #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in(in_v), .en_in(en_in), .out_ready(out_ready),
        .out_idx(idx1), .out_valid(val1), .pending(pend1), .overflow(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] v, input int k);
        int i;
        if (k == 0) begin
            i = 0;
            while (i < 15 && !v[i]) i++;
        end else begin
            i = 15;
            while (i > 0 && !v[i]) i--;
        end
        return i;
    endfunction

    // Model update from the request set semantics.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = '0;
                m_idx[k]  = 0;
                m_val[k]  = 1'b0;
                m_ovf[k]  = 1'b0;
            end else begin
                m_acc = m_val[k] && out_ready;
                m_rem = m_pend[k];
                if (m_acc) m_rem[m_idx[k]] = 1'b0;
                m_cap = en_in ? in_v : 16'h0;
                if ((m_cap & m_rem) != 16'h0) m_ovf[k] = 1'b1;
                if (!m_val[k] || m_acc) begin
                    if (m_rem != 16'h0) begin
                        m_idx[k] = pick(m_rem, k);
                        m_val[k] = 1'b1;
                    end else begin
                        m_val[k] = 1'b0;
                    end
                end
                m_pend[k] = m_rem | m_cap;
            end
        end
        if (rst) check_en = 1'b1;
    end

    // Completed handshakes
    always @(posedge clk) begin
        if (!rst) begin
            if (val0 && out_ready) log0.push_back(int'(idx0));
            if (val1 && out_ready) log1.push_back(int'(idx1));
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("lsb_pending", 32'(pend0), 32'(m_pend[0]));
            chk("lsb_valid",   32'(val0),  32'(m_val[0]));
            chk("lsb_ovf",     32'(ovf0),  32'(m_ovf[0]));
            if (m_val[0]) chk("lsb_idx", 32'(idx0), 32'(m_idx[0]));
            chk("msb_pending", 32'(pend1), 32'(m_pend[1]));
            chk("msb_valid",   32'(val1),  32'(m_val[1]));
            chk("msb_ovf",     32'(ovf1),  32'(m_ovf[1]));
            if (m_val[1]) chk("msb_idx", 32'(idx1), 32'(m_idx[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    // Expected sequence packed as nibbles, element 0 in the lowest nibble.
    task automatic chk_log(input string name, input int k, input int n, input logic [63:0] exp);
        logic [63:0] e;
        int          sz;
        e  = exp;
        sz = (k == 0) ? log0.size() : log1.size();
        chk({name, "_len"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            chk({name, "_item"}, 32'((k == 0) ? log0[i] : log1[i]), 32'(e[4*i +: 4]));
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        in_v = v;
        @(negedge clk);
        in_v = 16'h0;
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b1; in_v = 16'hFFFF; out_ready = 1'b1;
        @(negedge clk);

        // Reset with all requests asserted
        cyc(2);
        rst = 1'b0; in_v = 16'h0;
        cyc(1);
        chk("rst_pending", 32'(pend0), 32'h0);
        chk("rst_valid",   32'(val0),  32'h0);
        chk("rst_ovf",     32'(ovf0),  32'h0);
        cyc(3);
        chk("rst_nolog", 32'(log0.size() + log1.size()), 32'h0);

        // Single request, 2-cycle latency
        clear_logs();
        pulse(16'h0400);
        chk("single_k_valid", 32'(val0), 32'h0);
        chk("single_k_pend",  32'(pend0), 32'h0400);
        cyc(1);
        chk("single_valid", 32'(val0), 32'h1);
        chk("single_idx",   32'(idx0), 32'd10);
        chk("single_idx_m", 32'(idx1), 32'd10);
        cyc(1);
        chk("single_done_valid", 32'(val0), 32'h0);
        chk("single_done_pend",  32'(pend0), 32'h0);
        chk_log("single_lsb", 0, 1, 64'hA);

        // Multi request, both priority orders
        clear_logs();
        pulse(16'h8421);
        cyc(6);
        chk_log("multi_lsb", 0, 4, 64'hFA50);
        chk_log("multi_msb", 1, 4, 64'h05AF);

        // Backpressure with a late higher-priority request
        clear_logs();
        out_ready = 1'b0;
        pulse(16'h0030);
        cyc(5);
        pulse(16'h0001);
        cyc(1);
        chk("bp_valid", 32'(val0), 32'h1);
        chk("bp_idx",   32'(idx0), 32'd4);
        chk("bp_idx_m", 32'(idx1), 32'd5);
        out_ready = 1'b1;
        cyc(5);
        chk_log("bp_lsb", 0, 3, 64'h504);
        chk_log("bp_msb", 1, 3, 64'h045);

        // Coalesced request on a presented, stalled index
        clear_logs();
        out_ready = 1'b0;
        pulse(16'h0008);
        cyc(2);
        chk("ovf_pre", 32'(ovf0), 32'h0);
        pulse(16'h0008);
        chk("ovf_set",  32'(ovf0), 32'h1);
        chk("ovf_pend", 32'(pend0), 32'h0008);
        out_ready = 1'b1;
        cyc(4);
        chk("ovf_sticky", 32'(ovf0), 32'h1);
        chk_log("ovf_once", 0, 1, 64'h3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("ovf_rst", 32'(ovf0), 32'h0);

        // Accept and re-request the same bit in one cycle
        clear_logs();
        out_ready = 1'b0;
        pulse(16'h0008);
        cyc(2);
        out_ready = 1'b1;
        pulse(16'h0008);
        chk("rereq_ovf",   32'(ovf0), 32'h0);
        chk("rereq_pend",  32'(pend0), 32'h0008);
        chk("rereq_valid", 32'(val0), 32'h0);
        cyc(3);
        chk_log("rereq", 0, 2, 64'h33);

        // Enable gating, then all 16 indices
        clear_logs();
        en_in = 1'b0; in_v = 16'hFFFF;
        cyc(10);
        chk("gate_pend",  32'(pend0), 32'h0);
        chk("gate_valid", 32'(val0),  32'h0);
        en_in = 1'b1;
        pulse(16'hFFFF);
        cyc(20);
        chk_log("all_lsb", 0, 16, 64'hFEDCBA9876543210);
        chk_log("all_msb", 1, 16, 64'h0123456789ABCDEF);

        // Reset mid-stream
        pulse(16'hF0F0);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("mid_rst_pend",  32'(pend1), 32'h0);
        chk("mid_rst_valid", 32'(val1),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
